// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - round-robin issue of NUM_REQ requesters onto one shared ALU with a registered CDB slot
module alu_issue_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][63:0]       req_a,
    input  logic [NUM_REQ-1:0][63:0]       req_b,
    input  logic [NUM_REQ-1:0][2:0]        req_op,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [63:0]                    alu_a,
    output logic [63:0]                    alu_b,
    output logic [2:0]                     alu_cntrl,
    input  logic [63:0]                    alu_result,
    input  logic                           alu_negative,
    input  logic                           alu_zero,
    input  logic                           alu_overflow,
    input  logic                           alu_carry_out,
    input  logic                           flush,
    output logic                           cdb_valid,
    input  logic                           cdb_ready,
    output logic [TAG_W-1:0]               cdb_tag,
    output logic [63:0]                    cdb_result,
    output logic [3:0]                     cdb_flags,
    output logic                           cdb_illegal
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  scan_idx;
    logic [PTR_W:0]    scan_sum;
    logic [PTR_W-1:0]  next_ptr;
    logic              found;
    logic              can_issue;
    logic [2:0]        sel_op;
    logic              sel_illegal;

    // reset_n also gates issue so nothing is granted while the core is held in reset
    assign can_issue = reset_n && !flush && ((state == EMPTY) || cdb_ready);

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (scan_sum >= (PTR_W+1)'(NUM_REQ))
                scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
            scan_idx = scan_sum[PTR_W-1:0];
            if (!found && can_issue && req_valid[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found)
            req_ready[grant_idx] = 1'b1;
    end

    assign sel_op      = req_op[grant_idx];
    assign sel_illegal = (sel_op == 3'b001) || (sel_op == 3'b111);
    assign next_ptr    = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

    // illegal opcodes run as PASS_B so the broadcast result is simply operand B
    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_cntrl = 3'b000;
        if (found) begin
            alu_a     = req_a[grant_idx];
            alu_b     = req_b[grant_idx];
            alu_cntrl = sel_illegal ? 3'b000 : sel_op;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= EMPTY;
            rr_ptr      <= '0;
            cdb_tag     <= '0;
            cdb_result  <= '0;
            cdb_flags   <= '0;
            cdb_illegal <= 1'b0;
        end else if (flush) begin
            state <= EMPTY;
        end else if (found) begin
            state       <= FULL;
            rr_ptr      <= next_ptr;
            cdb_tag     <= req_tag[grant_idx];
            cdb_result  <= alu_result;
            cdb_flags   <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
            cdb_illegal <= sel_illegal;
        end else if (cdb_ready) begin
            state <= EMPTY;
        end
    end

    assign cdb_valid = (state == FULL);

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb/tb_alu_issue_arbiter.sv - directed self-checking bench for alu_issue_arbiter
module tb_alu_issue_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 6;

    logic                          clk;
    logic                          reset_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][63:0]      req_a;
    logic [NUM_REQ-1:0][63:0]      req_b;
    logic [NUM_REQ-1:0][2:0]       req_op;
    logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
    logic [NUM_REQ-1:0]            req_ready;
    logic [63:0]                   alu_a;
    logic [63:0]                   alu_b;
    logic [2:0]                    alu_cntrl;
    logic [63:0]                   alu_result;
    logic                          alu_negative;
    logic                          alu_zero;
    logic                          alu_overflow;
    logic                          alu_carry_out;
    logic                          flush;
    logic                          cdb_valid;
    logic                          cdb_ready;
    logic [TAG_W-1:0]              cdb_tag;
    logic [63:0]                   cdb_result;
    logic [3:0]                    cdb_flags;
    logic                          cdb_illegal;

    int checks;
    int failures;

    alu_issue_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .req_tag(req_tag), .req_ready(req_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
        .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .flush(flush), .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
        .cdb_tag(cdb_tag), .cdb_result(cdb_result), .cdb_flags(cdb_flags),
        .cdb_illegal(cdb_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared ALU: 000 pass B, 010 add, 011 sub
    logic [64:0] alu_sum;
    always_comb begin
        alu_sum       = '0;
        alu_overflow  = 1'b0;
        alu_carry_out = 1'b0;
        case (alu_cntrl)
            3'b010: begin
                alu_sum       = {1'b0, alu_a} + {1'b0, alu_b};
                alu_carry_out = alu_sum[64];
                alu_overflow  = (alu_a[63] == alu_b[63]) && (alu_sum[63] != alu_a[63]);
            end
            3'b011: begin
                alu_sum       = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
                alu_carry_out = alu_sum[64];
                alu_overflow  = (alu_a[63] != alu_b[63]) && (alu_sum[63] != alu_a[63]);
            end
            default: alu_sum = {1'b0, alu_b};
        endcase
        alu_result   = alu_sum[63:0];
        alu_negative = alu_result[63];
        alu_zero     = (alu_result == 64'd0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] op, input logic [TAG_W-1:0] tag);
        req_valid[i] = 1'b1;
        req_a[i]     = a;
        req_b[i]     = b;
        req_op[i]    = op;
        req_tag[i]   = tag;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_tag   = '0;
        flush     = 1'b0;
        cdb_ready = 1'b0;

        // reset values
        #12;
        chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
        chk("rst_cdb_result", cdb_result, 64'd0);
        chk("rst_cdb_flags", 64'(cdb_flags), 64'd0);
        chk("rst_cdb_illegal", 64'(cdb_illegal), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_alu_cntrl", 64'(alu_cntrl), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // single issue
        set_req(1, 64'd5, 64'd3, 3'b010, 6'd7);
        cdb_ready = 1'b1;
        settle();
        chk("single_grant", 64'(req_ready), 64'b0010);
        chk("single_alu_a", alu_a, 64'd5);
        chk("single_alu_b", alu_b, 64'd3);
        chk("single_alu_cntrl", 64'(alu_cntrl), 64'b010);
        tick();
        req_valid = '0;
        settle();
        chk("single_cdb_valid", 64'(cdb_valid), 64'd1);
        chk("single_cdb_tag", 64'(cdb_tag), 64'd7);
        chk("single_cdb_result", cdb_result, 64'd8);
        chk("single_cdb_flags", 64'(cdb_flags), 64'd0);
        chk("single_cdb_illegal", 64'(cdb_illegal), 64'd0);
        tick();
        settle();
        chk("single_drain", 64'(cdb_valid), 64'd0);

        // pointer back to 0 before the fairness run
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // round robin with everyone valid
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 64'(100 + i), 64'd0, 3'b010, TAG_W'(i));
        for (int k = 0; k < 6; k++) begin
            settle();
            chk($sformatf("rr_grant_%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
            if (k > 0) begin
                chk($sformatf("rr_valid_%0d", k), 64'(cdb_valid), 64'd1);
                chk($sformatf("rr_tag_%0d", k), 64'(cdb_tag), 64'((k - 1) % 4));
            end
            tick();
        end
        settle();
        chk("rr_tag_last", 64'(cdb_tag), 64'd1);
        chk("rr_grant_6", 64'(req_ready), 64'b0100);
        tick();
        settle();
        chk("rr_grant_7", 64'(req_ready), 64'b1000);
        tick();

        // backpressure while holding tag 3
        cdb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("bp_grant_%0d", k), 64'(req_ready), 64'd0);
            chk($sformatf("bp_valid_%0d", k), 64'(cdb_valid), 64'd1);
            chk($sformatf("bp_tag_%0d", k), 64'(cdb_tag), 64'd3);
            chk($sformatf("bp_result_%0d", k), cdb_result, 64'd103);
            tick();
        end
        cdb_ready = 1'b1;
        settle();
        chk("bp_release_grant", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        settle();
        chk("bp_release_tag", 64'(cdb_tag), 64'd0);
        chk("bp_release_result", cdb_result, 64'd100);
        tick();

        // subtraction overflow, then back-to-back zero result
        set_req(0, 64'h8000_0000_0000_0000, 64'd1, 3'b011, 6'd20);
        settle();
        chk("sub_grant_wrap", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        set_req(2, 64'h45_BDE7_3621, 64'h45_BDE7_3621, 3'b011, 6'd21);
        settle();
        chk("sub_ovf_result", cdb_result, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("sub_ovf_flags", 64'(cdb_flags), 64'b0011);
        chk("sub_b2b_grant", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        settle();
        chk("sub_zero_tag", 64'(cdb_tag), 64'd21);
        chk("sub_zero_result", cdb_result, 64'd0);
        chk("sub_zero_flags", 64'(cdb_flags), 64'b0101);

        // illegal opcodes 111 then 001
        set_req(3, 64'hDEAD, 64'h1234, 3'b111, 6'd22);
        settle();
        chk("ill_grant", 64'(req_ready), 64'b1000);
        chk("ill_alu_cntrl", 64'(alu_cntrl), 64'd0);
        tick();
        req_valid = '0;
        set_req(1, 64'd9, 64'h55, 3'b001, 6'd23);
        settle();
        chk("ill_result", cdb_result, 64'h1234);
        chk("ill_flag", 64'(cdb_illegal), 64'd1);
        chk("ill_flags", 64'(cdb_flags), 64'd0);
        tick();
        req_valid = '0;
        cdb_ready = 1'b0;
        settle();
        chk("ill001_result", cdb_result, 64'h55);
        chk("ill001_flag", 64'(cdb_illegal), 64'd1);

        // flush while FULL and stalled
        set_req(2, 64'd1, 64'd2, 3'b010, 6'd24);
        flush = 1'b1;
        settle();
        chk("flush_no_grant", 64'(req_ready), 64'd0);
        chk("flush_alu_a", alu_a, 64'd0);
        tick();
        flush     = 1'b0;
        cdb_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 64'(200 + i), 64'd0, 3'b010, TAG_W'(30 + i));
        settle();
        chk("flush_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("flush_ptr_held", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        settle();
        chk("flush_next_tag", 64'(cdb_tag), 64'd32);

        // async reset while FULL
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("arst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("arst_req_ready", 64'(req_ready), 64'd0);
        tick();
        reset_n = 1'b1;
        settle();
        chk("arst_first_grant", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        settle();
        chk("arst_tag", 64'(cdb_tag), 64'd31);
        chk("arst_result", cdb_result, 64'd201);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares the single combinational 64-bit ALU among `NUM_REQ` reservation-station requesters in the out-of-order core. Each cycle it selects one ready requester by round-robin and drives that requester's operands and opcode onto the ALU. It captures the ALU result and flags into a one-entry output register and broadcasts them on the common data bus (CDB) with a valid/ready handshake. It handles CDB backpressure and pipeline flush.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `TAG_W`, 6, width of the destination tag

Ports:
- `clk` in 1 — single clock, rising edge
- `reset_n` in 1 — asynchronous, active-low reset
- `req_valid` in NUM_REQ — requester i has an operation pending
- `req_a`, `req_b` in NUM_REQ×64 — operands per requester
- `req_op` in NUM_REQ×3 — ALU opcode per requester
- `req_tag` in NUM_REQ×TAG_W — destination tag per requester
- `req_ready` out NUM_REQ — one-hot grant; the operation is accepted when `req_valid[i] & req_ready[i]`
- `alu_a`, `alu_b` out 64 — operands to the ALU
- `alu_cntrl` out 3 — opcode to the ALU
- `alu_result` in 64 — result from the ALU
- `alu_negative`, `alu_zero`, `alu_overflow`, `alu_carry_out` in 1 each — flags from the ALU
- `flush` in 1 — squash: drop buffered result, grant nothing this cycle
- `cdb_valid` out 1 — broadcast valid
- `cdb_ready` in 1 — CDB accepts the broadcast this cycle
- `cdb_tag` out TAG_W — tag of the broadcast result
- `cdb_result` out 64 — result of the broadcast
- `cdb_flags` out 4 — {negative, zero, overflow, carry_out}
- `cdb_illegal` out 1 — the opcode was 001 or 111

## Operation
- Output register state: EMPTY / FULL, reflected on `cdb_valid`.
- `can_issue = !flush & (state==EMPTY | cdb_ready)`.
- Arbitration: when `can_issue` holds, grant the first `req_valid` requester starting at pointer `rr_ptr` and wrapping modulo NUM_REQ. `req_ready` is one-hot or zero, and is combinational from `req_valid`, `rr_ptr`, `state`, `cdb_ready` and `flush`.
- On accept:
  - `rr_ptr <= grantee+1` (mod NUM_REQ).
  - Output register loads the tag, `alu_result`, the flags, and the illegal bit.
  - State becomes FULL.
- Without an accept, `rr_ptr` holds.
- ALU drive:
  - When a grant is made, `alu_a`/`alu_b`/`alu_cntrl` equal the grantee's fields.
  - Otherwise `alu_a`/`alu_b` are 0 and `alu_cntrl` is 000 (PASS_B).
- Opcodes 001 and 111 are illegal. They are forwarded with `alu_cntrl`=000 (PASS_B); the buffered `cdb_illegal` is 1 and the result is `req_b`.
- Flags: overflow and carry_out are forwarded unmodified for every opcode. Consumers ignore them for non-add/sub operations.
- CDB:
  - FULL with `cdb_ready`=1 and no new accept → EMPTY.
  - FULL with `cdb_ready`=1 and a new accept → stays FULL with the new contents (back-to-back issue).
  - FULL with `cdb_ready`=0 → all outputs hold stable, no grant.
- `flush`=1: state → EMPTY at the next edge regardless of `cdb_ready`, no grant, `rr_ptr` holds.

## Timing
- Reset (async, `reset_n`=0):
  - Output register: `cdb_valid`=0, `cdb_tag`=0, `cdb_result`=0, `cdb_flags`=0, `cdb_illegal`=0.
  - Control: `rr_ptr`=0, `req_ready`=0.
  - ALU drive: `alu_a`/`alu_b`=0, `alu_cntrl`=000.
- Reset mid-operation discards the buffered result; the first grant after release is evaluated from `rr_ptr`=0.
- Latency: an accept at edge N puts `cdb_valid`=1 with that result in the cycle after N. One-cycle issue-to-broadcast.
- Throughput: one operation per cycle while `cdb_ready`=1.
- `cdb_*` outputs come from flops. `req_ready` and `alu_*` are combinational.
- Requesters must hold fields stable while `req_valid`=1 and not yet accepted. They may drop `req_valid` at any time before the accept.

## Test plan
- Single issue: after reset, req1 asserts valid with A=5, B=3, op=010, tag=7; `cdb_ready`=1 → `req_ready`=0010 in that cycle. Next cycle `cdb_valid`=1, tag=7, result=8, flags=0000, illegal=0.
- Round-robin fairness: all 4 requesters continuously valid, `cdb_ready`=1 → grant order 0,1,2,3,0,1 on consecutive cycles, and `cdb_tag` follows the same sequence one cycle later.
- Backpressure: FULL holding tag 3 with `cdb_ready`=0 for 3 cycles → `req_ready`=0 and `cdb_*` unchanged on each cycle. When `cdb_ready` rises, the same cycle grants the next requester; the following cycle shows the new tag.
- Subtraction and flags: A=0x8000000000000000, B=1, op=011 → result=0x7FFFFFFFFFFFFFFF, overflow=1, negative=0, zero=0. Then A=B=0x45BDE73621, op=011 → result 0 with zero=1.
- Illegal opcode: op=111, B=0x1234 → `alu_cntrl`=000, `cdb_result`=0x1234, `cdb_illegal`=1.
- Flush and reset:
  - FULL with `cdb_ready`=0, `flush` pulsed with req2 valid → no grant that cycle, next cycle `cdb_valid`=0, `rr_ptr` unchanged.
  - `reset_n` low while FULL → `cdb_valid` drops immediately (asynchronously); after release, the first grant goes to the lowest-index valid requester.
